// File: rtl/fp_square.sv
// fp_square: multi-cycle IEEE-754 squarer (res = op*op), shift-add multiply then normalize, RNE, pack.
// Latency MAN_W+3 cycles from start, start while busy restarts; define FP_SQUARE_FLAGS_EN to drive the flags.
module fp_square #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op,
  output logic              done,
  output logic              overflow,
  output logic              underflow,
  output logic              exception,
  output logic [DATA_W-1:0] res
);

  localparam int MAN_W  = DATA_W - EXP_W;
  localparam int FRAC_W = MAN_W - 1;
  localparam int PROD_W = 2 * MAN_W;
  localparam int XW     = EXP_W + 2;
  localparam int CNT_W  = $clog2(MAN_W);

  localparam logic signed [XW-1:0] BIAS_X   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X   = XW'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W - 1);

  localparam logic [DATA_W-1:0] RES_INF  = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0] RES_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_RND,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-2:0]       opm_q, opm_d;
  logic [MAN_W-1:0]        mplier_q, mplier_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PROD_W-1:0]       acc_q, acc_d;
  logic [PROD_W-2:0]       nrm_q, nrm_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic [FRAC_W-1:0]       frac_q, frac_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       res_q, res_d;

  // The square is never negative, so the operand sign is intentionally dropped.
  logic unused_sign;
  assign unused_sign = op[DATA_W-1];

  logic [EXP_W-1:0]  e_fld;
  logic [FRAC_W-1:0] f_fld;
  logic [MAN_W-1:0]  mcand;
  logic              e_zero;
  logic              e_ones;
  logic [MAN_W:0]    psum;
  logic              g_bit;
  logic              r_bit;
  logic              s_bit;
  logic              rnd_inc;
  logic [FRAC_W:0]   rsum;

  assign e_fld  = opm_q[DATA_W-2:FRAC_W];
  assign f_fld  = opm_q[FRAC_W-1:0];
  assign mcand  = {1'b1, f_fld};
  assign e_zero = (e_fld == '0);
  assign e_ones = &e_fld;

  // Right-shifting accumulator: add the multiplicand into the upper half, shift one bit out per cycle.
  assign psum = {1'b0, acc_q[PROD_W-1:MAN_W]} + {1'b0, (mplier_q[0] ? mcand : {MAN_W{1'b0}})};

  assign g_bit   = nrm_q[MAN_W-1];
  assign r_bit   = nrm_q[MAN_W-2];
  assign s_bit   = |nrm_q[MAN_W-3:0];
  assign rnd_inc = g_bit & (r_bit | s_bit | nrm_q[MAN_W]);
  assign rsum    = {1'b0, nrm_q[PROD_W-2:MAN_W]} + {{FRAC_W{1'b0}}, rnd_inc};

`ifdef FP_SQUARE_FLAGS_EN
  logic [2:0] flg_q, flg_d;
`endif

  always_comb begin
    state_d  = state_q;
    opm_d    = opm_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    nrm_d    = nrm_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    done_d   = done_q;
    res_d    = res_q;
`ifdef FP_SQUARE_FLAGS_EN
    flg_d    = flg_q;
`endif

    case (state_q)
      S_MUL: begin
        acc_d    = {psum, acc_q[MAN_W-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // Product lies in [1,4); the leading one is dropped and the exponent bumped when P >= 2.
        if (acc_q[PROD_W-1]) begin
          nrm_d = acc_q[PROD_W-2:0];
        end else begin
          nrm_d = {acc_q[PROD_W-3:0], 1'b0};
        end
        exp_d   = {1'b0, e_fld, 1'b0} - BIAS_X + {{(XW-1){1'b0}}, acc_q[PROD_W-1]};
        state_d = S_RND;
      end

      S_RND: begin
        // A carry out of the fraction leaves it all zero, which is 1.0 at the next exponent.
        frac_d  = rsum[FRAC_W-1:0];
        exp_d   = exp_q + {{(XW-1){1'b0}}, rsum[FRAC_W]};
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef FP_SQUARE_FLAGS_EN
        flg_d   = 3'b000;
`endif
        if (e_ones && (f_fld != '0)) begin
          res_d = RES_QNAN;
`ifdef FP_SQUARE_FLAGS_EN
          flg_d = 3'b001;
`endif
        end else if (e_ones) begin
          res_d = RES_INF;
        end else if (e_zero) begin
          res_d = '0;
        end else if (exp_q >= EMAX_X) begin
          res_d = RES_INF;
`ifdef FP_SQUARE_FLAGS_EN
          flg_d = 3'b100;
`endif
        end else if (exp_q[XW-1] || (exp_q == '0)) begin
          res_d = '0;
`ifdef FP_SQUARE_FLAGS_EN
          flg_d = 3'b010;
`endif
        end else begin
          res_d = {1'b0, exp_q[EXP_W-1:0], frac_q};
        end
      end

      default: begin
      end
    endcase

    // start wins in every state, so a start while busy simply restarts.
    if (start) begin
      opm_d    = op[DATA_W-2:0];
      mplier_d = {1'b1, op[FRAC_W-1:0]};
      acc_d    = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      state_d  = S_MUL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opm_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      nrm_q    <= '0;
      exp_q    <= '0;
      frac_q   <= '0;
      done_q   <= 1'b1;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      opm_q    <= opm_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      nrm_q    <= nrm_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      done_q   <= done_d;
      res_q    <= res_d;
    end
  end

`ifdef FP_SQUARE_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg_q <= 3'b000;
    end else begin
      flg_q <= flg_d;
    end
  end

  assign overflow  = flg_q[2];
  assign underflow = flg_q[1];
  assign exception = flg_q[0];
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
  assign exception = 1'b0;
`endif

  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_fp_square.sv
// Bench for fp_square: integer-arithmetic reference model, per-cycle compare process, literal vectors.
module tb_fp_square;

  localparam int LAT = 27;
`ifdef FP_SQUARE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op = 32'h0;
  logic        done;
  logic        overflow;
  logic        underflow;
  logic        exception;
  logic [31:0] res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_square #(.DATA_W(32), .EXP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception),
    .res       (res)
  );

  // Returns {overflow, underflow, exception, res} computed with plain integer arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a);
    int              e;
    int              ex;
    int              be;
    int              sh;
    longint unsigned m;
    longint unsigned p;
    longint unsigned q;
    longint unsigned rem;
    longint unsigned half;
    logic [2:0]      f;
    logic [31:0]     r;
    logic [63:0]     qb;
    logic [31:0]     beb;
    e = int'(a[30:23]);
    f = 3'b000;
    r = 32'h0;
    if (e == 255) begin
      if (a[22:0] != 23'h0) begin
        r = 32'h7FC00000;
        f = 3'b001;
      end else begin
        r = 32'h7F800000;
      end
    end else if (e != 0) begin
      m  = {40'd0, 1'b1, a[22:0]};
      p  = m * m;
      ex = 2 * (e - 127);
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        ex = ex + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q  = q >> 1;
        ex = ex + 1;
      end
      be = ex + 127;
      if (be >= 255) begin
        r = 32'h7F800000;
        f = 3'b100;
      end else if (be <= 0) begin
        r = 32'h0;
        f = 3'b010;
      end else begin
        qb  = q;
        beb = be;
        r   = {1'b0, beb[7:0], qb[22:0]};
      end
    end
    if (!FLAGS_ON) f = 3'b000;
    return {f, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Expected-behaviour tracker: edges since the last sampled start.
  bit          busy  = 1'b0;
  int          since = 0;
  logic [34:0] pend  = 35'h0;
  logic [34:0] cur   = 35'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      since <= 0;
      cur   <= 35'h0;
    end else if (start) begin
      busy  <= 1'b1;
      since <= 0;
      pend  <= model(op);
    end else if (busy) begin
      since <= since + 1;
      if (since + 1 == LAT) begin
        busy <= 1'b0;
        cur  <= pend;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_done", {63'h0, done}, 64'h1);
      check("rst_out", {29'h0, overflow, underflow, exception, res}, 64'h0);
    end else if (busy) begin
      if (since != 0) check("busy_done", {63'h0, done}, 64'h0);
    end else begin
      check("idle_done", {63'h0, done}, 64'h1);
      check("idle_out", {29'h0, overflow, underflow, exception, res}, {29'h0, cur});
    end
  end

  task automatic issue(input logic [31:0] a);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    check({nm, "_lat"}, 64'(n), 64'(LAT));
  endtask

  task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] want_r,
                     input logic [2:0] want_f);
    logic [2:0] wf;
    wf = FLAGS_ON ? want_f : 3'b000;
    check({nm, "_model"}, {29'h0, model(a)}, {29'h0, wf, want_r});
    issue(a);
    wait_done(nm);
    check({nm, "_res"}, {29'h0, overflow, underflow, exception, res}, {29'h0, wf, want_r});
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 99));
    if (sel < 4)       e = 8'd0;
    else if (sel < 8)  e = 8'd255;
    else if (sel < 75) e = 8'($urandom_range(40, 215));
    else               e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = 23'h7FFFFF - 23'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) f = f & 23'h7FF000;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {63'h0, done}, 64'h1);
    check("reset_res", {32'h0, res}, 64'h0);
    check("reset_flags", {61'h0, overflow, underflow, exception}, 64'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    vec("three",   32'h40400000, 32'h41100000, 3'b000);
    vec("neg_two", 32'hC0000000, 32'h40800000, 3'b000);
    vec("one_p5",  32'h3FC00000, 32'h40100000, 3'b000);
    vec("rne",     32'h3F800001, 32'h3F800002, 3'b000);
    vec("ovf",     32'h60AD78EC, 32'h7F800000, 3'b100);
    vec("unf",     32'h1E3CE508, 32'h00000000, 3'b010);
    vec("nan",     32'h7FC00000, 32'h7FC00000, 3'b001);
    vec("ninf",    32'hFF800000, 32'h7F800000, 3'b000);
    vec("zero",    32'h80000000, 32'h00000000, 3'b000);
    vec("subn",    32'h00000123, 32'h00000000, 3'b000);

    // Restart: second start aborts the first; full latency counts from the second.
    issue(32'h40400000);
    repeat (9) @(posedge clk);
    issue(32'h3FC00000);
    wait_done("restart");
    check("restart_res", {32'h0, res}, 64'h40100000);

    // Asynchronous reset in the middle of the multiply.
    issue(32'h40400000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_done", {63'h0, done}, 64'h1);
    check("midrst_res", {32'h0, res}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec("after_rst", 32'h40400000, 32'h41100000, 3'b000);

    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      issue(a);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 24)) @(posedge clk);
        a = rand_op();
        issue(a);
      end
      wait_done("rand");
      check("rand_res", {29'h0, overflow, underflow, exception, res}, {29'h0, model(a)});
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
